// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite master port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

  // Master FSM states: one request is in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR_DATA,
    ST_WRESP
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_port.sv
// Sequential AXI4-Lite master: one core request in, one AR/R or AW+W/B transaction out.
// Latency: accept at edge N -> AXI valids from N+1 -> resp_valid at N+3 with a zero-wait slave.
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle strobe with no backpressure.
//
// Ports:
//   clk, rstn                        clock, async active-low reset
//   req_valid/req_ready/req_we/...   core request (addr, wdata, wstrb)
//   resp_valid/resp_rdata/resp_err   completion strobe, read data (0 for writes), error flag
//   m_ar*/m_r*/m_aw*/m_w*/m_b*       AXI4-Lite master channels
module axi_lite_master_port
  import axi_lite_pkg::*;
#(
  parameter logic [2:0] PROT = PROT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  // core request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  // core response side
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AR channel
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [2:0]  m_arprot,
  // R channel
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // AW channel
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [2:0]  m_awprot,
  // W channel
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  // B channel
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        aw_hs;
  logic        w_hs;
  logic        aw_done_d;
  logic        w_done_d;

  // AW and W complete independently; a flag remembers each finished handshake
  // so the FSM only leaves WADDR_DATA once both have been seen.
  assign aw_hs     = awvalid_q & m_awready;
  assign w_hs      = wvalid_q & m_wready;
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // Response strobe lasts a single cycle unless re-armed below.
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WADDR_DATA;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RADDR;
            end
          end
        end
        ST_RADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_rvalid) begin
            rready_q     <= 1'b0;
            resp_rdata_q <= m_rdata;
            resp_err_q   <= (m_rresp != RESP_OKAY);
            resp_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WADDR_DATA: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= ST_WRESP;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        ST_WRESP: begin
          if (m_bvalid) begin
            bready_q     <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= (m_bresp != RESP_OKAY);
            resp_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign m_araddr  = addr_q;
  assign m_arvalid = arvalid_q;
  assign m_arprot  = PROT;
  assign m_rready  = rready_q;
  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_awprot  = PROT;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

endmodule
